// File: rtl/xbar_slave_mem.sv
// Pipelined request/response memory slave for a cross-bar slave port, with in-order read responses.
// Optional address range checking is enabled by defining XBAR_SLAVE_ADDR_CHECK_EN.
module xbar_slave_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_AW     = 6,
    parameter int RD_LAT     = 2,
    parameter int RESP_DEPTH = 4
) (
    input  logic                                  clk_pll,
    input  logic                                  rst_in,
    input  logic                                  slave_req,
    input  logic                                  slave_cmd,
    input  logic [ADDR_WIDTH-1:0]                 slave_addr,
    input  logic [DATA_WIDTH-1:0]                 slave_wdata,
    output logic                                  slave_ack,
    output logic                                  slave_resp,
    input  logic                                  slave_resp_ready,
    output logic [DATA_WIDTH-1:0]                 slave_rdata,
    output logic                                  slave_err,
    output logic [$clog2(RESP_DEPTH+1)-1:0]       rd_pending
);

    localparam int PW        = $clog2(RESP_DEPTH + 1);
    localparam int FAW       = $clog2(RESP_DEPTH);
    localparam int MEM_DEPTH = 2 ** MEM_AW;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  r_pv [RD_LAT];
    logic                  r_pe [RD_LAT];
    logic [DATA_WIDTH-1:0] r_pd [RD_LAT];

    logic [DATA_WIDTH-1:0] r_fifo_data [RESP_DEPTH];
    logic                  r_fifo_err  [RESP_DEPTH];
    logic [FAW-1:0]        r_wr_ptr;
    logic [FAW-1:0]        r_rd_ptr;
    logic [PW-1:0]         r_count;
    logic [PW-1:0]         r_pending;

    logic              w_oor;
    logic [MEM_AW-1:0] w_idx;
    logic              w_wr_en;
    logic              w_rd_acc;
    logic              w_push;
    logic              w_pop;
    logic              w_head_err;

`ifdef XBAR_SLAVE_ADDR_CHECK_EN
    assign w_oor = |slave_addr[ADDR_WIDTH-1:MEM_AW];
`else
    // Upper address bits are intentionally ignored: addresses wrap modulo the memory depth.
    logic w_unused_addr;
    assign w_unused_addr = ^slave_addr[ADDR_WIDTH-1:MEM_AW];
    assign w_oor         = 1'b0;
`endif

    assign w_idx     = slave_addr[MEM_AW-1:0];
    // Read credit is taken from the registered outstanding count, so the FIFO can never overflow.
    assign slave_ack = slave_req & rst_in & (slave_cmd | (r_pending < PW'(RESP_DEPTH)));
    assign w_wr_en   = slave_ack & slave_cmd & ~w_oor;
    assign w_rd_acc  = slave_ack & ~slave_cmd;

    // Memory array and data pipeline carry no reset so they map onto block RAM and plain registers.
    always_ff @(posedge clk_pll) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= slave_wdata;
        end
        if (w_rd_acc) begin
            r_pd[0] <= r_mem[w_idx];
        end
        for (int i = 1; i < RD_LAT; i++) begin
            r_pd[i] <= r_pd[i-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            logic w_v_in;
            logic w_e_in;
            if (gi == 0) begin : g_first
                assign w_v_in = w_rd_acc;
                assign w_e_in = w_rd_acc & w_oor;
            end else begin : g_next
                assign w_v_in = r_pv[gi-1];
                assign w_e_in = r_pe[gi-1];
            end
            always_ff @(posedge clk_pll or negedge rst_in) begin
                if (!rst_in) begin
                    r_pv[gi] <= 1'b0;
                    r_pe[gi] <= 1'b0;
                end else begin
                    r_pv[gi] <= w_v_in;
                    r_pe[gi] <= w_e_in;
                end
            end
        end
    endgenerate

    assign w_push = r_pv[RD_LAT-1];
    assign w_pop  = slave_resp & slave_resp_ready;

    always_ff @(posedge clk_pll) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= r_pd[RD_LAT-1];
            r_fifo_err[r_wr_ptr]  <= r_pe[RD_LAT-1];
        end
    end

    always_ff @(posedge clk_pll or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_pending <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FAW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FAW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + PW'(1);
                2'b01:   r_count <= r_count - PW'(1);
                default: r_count <= r_count;
            endcase
            case ({w_rd_acc, w_pop})
                2'b10:   r_pending <= r_pending + PW'(1);
                2'b01:   r_pending <= r_pending - PW'(1);
                default: r_pending <= r_pending;
            endcase
        end
    end

    // FIFO head drives the response outputs directly; data is forced to 0 when idle or errored.
    assign w_head_err  = r_fifo_err[r_rd_ptr];
    assign slave_resp  = (r_count != '0);
    assign slave_rdata = (slave_resp && !w_head_err) ? r_fifo_data[r_rd_ptr] : '0;
    assign rd_pending  = r_pending;

`ifdef XBAR_SLAVE_ADDR_CHECK_EN
    assign slave_err = slave_resp & w_head_err;
`else
    assign slave_err = 1'b0;
`endif

endmodule

// File: tb/tb_xbar_slave_mem.sv
// Randomised self-checking bench for xbar_slave_mem against a transaction-level model
// (word array plus a queue of expected responses, each tagged with its earliest visible cycle).
module tb_xbar_slave_mem;

    localparam int DW    = 16;
    localparam int AW    = 32;
    localparam int MAW   = 6;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic          clk_pll = 1'b0;
    logic          rst_in  = 1'b1;
    logic          slave_req = 1'b0;
    logic          slave_cmd = 1'b0;
    logic [AW-1:0] slave_addr = '0;
    logic [DW-1:0] slave_wdata = '0;
    logic          slave_ack;
    logic          slave_resp;
    logic          slave_resp_ready = 1'b0;
    logic [DW-1:0] slave_rdata;
    logic          slave_err;
    logic [2:0]    rd_pending;

    xbar_slave_mem #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_AW(MAW), .RD_LAT(LAT), .RESP_DEPTH(DEPTH)
    ) dut (
        .clk_pll(clk_pll), .rst_in(rst_in), .slave_req(slave_req), .slave_cmd(slave_cmd),
        .slave_addr(slave_addr), .slave_wdata(slave_wdata), .slave_ack(slave_ack),
        .slave_resp(slave_resp), .slave_resp_ready(slave_resp_ready), .slave_rdata(slave_rdata),
        .slave_err(slave_err), .rd_pending(rd_pending)
    );

    always #5 clk_pll = ~clk_pll;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            rdy;
    } resp_t;

    resp_t         q[$];
    logic [DW-1:0] m_mem [64];
    int            m_pend = 0;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    logic          e_ack, e_resp, e_err;
    logic [DW-1:0] e_rdata;
    logic [21:0]   o_vec, e_vec;

    function automatic logic addr_oor(input logic [AW-1:0] a);
`ifdef XBAR_SLAVE_ADDR_CHECK_EN
        return |a[AW-1:MAW];
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input logic r, input logic c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        slave_req   = r;
        slave_cmd   = c;
        slave_addr  = a;
        slave_wdata = d;
    endtask

    // Advance one clock: sample outputs/expectations at the falling edge, then apply the
    // transaction rules to the model at the rising edge. Returns 1 ns after the rising edge.
    task automatic cycle();
        logic pop;
        @(negedge clk_pll);
        if (!rst_in) begin
            q.delete();
            m_pend = 0;
        end
        e_ack   = slave_req && rst_in && (slave_cmd || m_pend < DEPTH);
        e_resp  = (q.size() > 0) && (q[0].rdy <= cyc);
        e_err   = e_resp ? q[0].err : 1'b0;
        e_rdata = (e_resp && !q[0].err) ? q[0].data : '0;
        e_vec   = {e_ack, e_resp, e_err, 3'(m_pend), e_rdata};
        o_vec   = {slave_ack, slave_resp, slave_err, rd_pending, slave_rdata};
        pop     = e_resp && slave_resp_ready;
        @(posedge clk_pll);
        cyc++;
        if (rst_in) begin
            if (pop) begin
                void'(q.pop_front());
                m_pend--;
            end
            if (e_ack) begin
                if (slave_cmd) begin
                    if (!addr_oor(slave_addr)) m_mem[slave_addr[MAW-1:0]] = slave_wdata;
                end else begin
                    if (addr_oor(slave_addr))
                        q.push_back('{data: '0, err: 1'b1, rdy: cyc + LAT});
                    else
                        q.push_back('{data: m_mem[slave_addr[MAW-1:0]], err: 1'b0, rdy: cyc + LAT});
                    m_pend++;
                end
            end
        end
        #1;
    endtask

    task automatic test_drain(input string name);
        drive(1'b0, 1'b0, '0, '0);
        slave_resp_ready = 1'b1;
        for (int t = 0; t < 40 && q.size() > 0; t++) begin
            cycle();
            checks++;
            if (o_vec !== e_vec) begin
                errors++;
                $display("FAIL %s_drain @%0d got ack,resp,err,pend,rdata=%h required %h", name, cyc, o_vec, e_vec);
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain_timeout: %0d responses still expected, required 0", name, q.size());
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 32'h5, 16'h1234);
        #1 rst_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (o_vec !== e_vec || o_vec !== '0) begin
                errors++;
                $display("FAIL reset_state @%0d got %h required %h", cyc, o_vec, e_vec);
            end
        end
        rst_in = 1'b1;
        cycle();
        checks++;
        if (o_vec !== e_vec || slave_ack !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ack @%0d got %h required %h", cyc, o_vec, e_vec);
        end
        drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_preload();
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 1'b1, AW'(i), (i < 8) ? DW'(16'h100 + i) : DW'($urandom));
            cycle();
            checks++;
            if (o_vec !== e_vec) begin
                errors++;
                $display("FAIL preload @%0d got %h required %h", cyc, o_vec, e_vec);
            end
        end
        drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_write_read();
        int resp_cycles = 0;
        slave_resp_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 0)      drive(1'b1, 1'b1, 32'h5, 16'hBEEF);
            else if (i == 1) drive(1'b1, 1'b0, 32'h5, '0);
            else             drive(1'b0, 1'b0, '0, '0);
            cycle();
            if (slave_resp === 1'b1 && slave_rdata === 16'hBEEF) resp_cycles++;
            checks++;
            if (o_vec !== e_vec) begin
                errors++;
                $display("FAIL write_read @%0d got %h required %h", cyc, o_vec, e_vec);
            end
        end
        checks++;
        if (resp_cycles != 1) begin
            errors++;
            $display("FAIL write_read_once: BEEF seen %0d cycles, required 1", resp_cycles);
        end
    endtask

    task automatic test_streaming();
        slave_resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, AW'(i), '0);
            cycle();
            checks++;
            if (o_vec !== e_vec || slave_ack !== 1'b1) begin
                errors++;
                $display("FAIL streaming @%0d got %h required %h", cyc, o_vec, e_vec);
            end
        end
        test_drain("streaming");
    endtask

    task automatic test_backpressure();
        bit done = 0;
        slave_resp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 4)       drive(1'b1, 1'b0, AW'(16 + i), '0);
            else if (i < 7)  drive(1'b1, 1'b0, AW'(20), '0);
            else             drive(1'b1, 1'b1, AW'(32), DW'($urandom));
            cycle();
            checks++;
            if (o_vec !== e_vec) begin
                errors++;
                $display("FAIL backpressure @%0d got %h required %h", cyc, o_vec, e_vec);
            end
        end
        slave_resp_ready = 1'b1;
        drive(1'b1, 1'b0, AW'(20), '0);
        for (int t = 0; t < 10 && !done; t++) begin
            cycle();
            done = e_ack;
            checks++;
            if (o_vec !== e_vec) begin
                errors++;
                $display("FAIL backpressure_release @%0d got %h required %h", cyc, o_vec, e_vec);
            end
        end
        test_drain("backpressure");
    endtask

    task automatic test_reset_midflight();
        slave_resp_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i < 3)       drive(1'b1, 1'b0, AW'(1 + i), '0);
            else if (i == 9) drive(1'b1, 1'b0, AW'(2), '0);
            else             drive(1'b0, 1'b0, '0, '0);
            if (i == 4) rst_in = 1'b0;
            if (i == 6) begin
                rst_in = 1'b1;
                slave_resp_ready = 1'b1;
            end
            cycle();
            checks++;
            if (o_vec !== e_vec) begin
                errors++;
                $display("FAIL reset_midflight @%0d got %h required %h", cyc, o_vec, e_vec);
            end
        end
        test_drain("reset_midflight");
    endtask

    task automatic test_address();
        slave_resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       drive(1'b1, 1'b0, 32'h40, '0);
                1:       drive(1'b1, 1'b1, 32'h41, 16'hA5A5);
                2:       drive(1'b1, 1'b0, 32'h1, '0);
                default: drive(1'b1, 1'b0, 32'h8000_0003, '0);
            endcase
            cycle();
            checks++;
            if (o_vec !== e_vec) begin
                errors++;
                $display("FAIL address @%0d got %h required %h", cyc, o_vec, e_vec);
            end
        end
        test_drain("address");
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int i = 0; i < 400; i++) begin
            a = AW'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a[AW-1:MAW] = (AW-MAW)'($urandom);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, DW'($urandom));
            slave_resp_ready = $urandom_range(0, 3) != 0;
            cycle();
            checks++;
            if (o_vec !== e_vec) begin
                errors++;
                $display("FAIL random @%0d got %h required %h", cyc, o_vec, e_vec);
            end
        end
        test_drain("random");
    endtask

    initial begin
        test_reset();
        test_preload();
        test_write_read();
        test_streaming();
        test_backpressure();
        test_reset_midflight();
        test_address();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xbar_slave_mem.md
# xbar_slave_mem

Parametrised memory slave for the cross-bar fabric. It replaces the fixed 4-read burst slave with a pipelined request/response endpoint. Accepts one write or read request per clk_pll cycle over the req/ack handshake and returns read data in order with configurable latency. Read responses are buffered in a response FIFO with master-side backpressure. It sits on a cross-bar slave port and is instantiated once per memory region.

## Interface
- DATA_WIDTH, 16, data bus width
- ADDR_WIDTH, 32, fabric address width
- MEM_AW, 6, memory index width; depth = 2**MEM_AW words
- RD_LAT, 2, read latency in cycles, legal 1..8
- RESP_DEPTH, 4, response FIFO depth and maximum outstanding reads; power of 2, ≥2
- Reset is rst_in, asynchronous, active-low. The clock is clk_pll.
- clk_pll  in  1  clock, all state on rising edge
- rst_in  in  1  async active-low reset
- slave_req  in  1  request valid
- slave_cmd  in  1  1 = write, 0 = read
- slave_addr  in  ADDR_WIDTH  word address
- slave_wdata  in  DATA_WIDTH  write data
- slave_ack  out  1  request accepted this cycle (combinational)
- slave_resp  out  1  read response valid
- slave_resp_ready  in  1  master consumes response
- slave_rdata  out  DATA_WIDTH  read data, 0 when slave_resp=0
- slave_err  out  1  response error flag (see Configuration)
- rd_pending  out  $clog2(RESP_DEPTH+1)  outstanding read count

## Operation
- Accept: request accepted on a rising edge where slave_req & slave_ack.
- slave_ack = slave_req & rst_in & (slave_cmd | (rd_pending < RESP_DEPTH)).
  - Writes are never stalled.
  - Reads stall when RESP_DEPTH reads are outstanding.
- Write: memory word slave_addr[MEM_AW-1:0] updated at the accept edge.
- Read: memory sampled at the accept edge. The result enters an RD_LAT-stage valid/data pipeline, then the response FIFO.
- Responses are returned strictly in acceptance order.
- rd_pending counts reads accepted but not yet consumed.
  - +1 on read accept, −1 on response consume (slave_resp & slave_resp_ready).
  - Unchanged when both occur on the same edge.
  - The ack decision uses the registered value.
- Pipeline never stalls. FIFO overflow is impossible by credit.
- Response FIFO head drives slave_resp/slave_rdata/slave_err directly. Output holds stable until consumed.
- Reset mid-operation: pipeline, FIFO and counters are cleared. In-flight reads are discarded, with no response. Memory contents are not reset.
- Reset values: slave_ack 0, slave_resp 0, slave_rdata 0, slave_err 0, rd_pending 0.

## Timing
- Read accepted at edge N with empty FIFO: slave_resp=1 with data from edge N+RD_LAT onward, until consumed.
- Back-to-back reads with slave_resp_ready=1: one response per cycle, throughput 1/cycle.
- Write at edge N, read of the same address accepted at edge N+1: returns the new data.
- Read accepted before a later write to the same address returns the old data.
- slave_resp_ready held 0: at most RESP_DEPTH reads are acked. The (RESP_DEPTH+1)th read sees slave_ack=0 until the first consume edge, and is acked in the cycle after that edge.
- Writes interleaved during a read stall are acked same cycle.

## Configuration
- Macro XBAR_SLAVE_ADDR_CHECK_EN.
- When defined, the address range is checked: any slave_addr with nonzero bits [ADDR_WIDTH-1:MEM_AW] is out of range.
  - Out-of-range writes are acked and dropped; memory is unchanged.
  - Out-of-range reads are acked and return slave_rdata=0 with slave_err=1, in order, with normal latency.
- When undefined, upper address bits are ignored and the address wraps modulo 2**MEM_AW.
  - slave_err is tied 0.

## Test plan
- Reset: rst_in low with slave_req=1 → slave_ack=0, slave_resp=0, rd_pending=0. Release → first write to 0x05 acked same cycle.
- Write 0x05←0xBEEF, then read 0x05 next cycle, RD_LAT=2, ready=1 → slave_resp high 2 cycles after the read accept, slave_rdata=0xBEEF for exactly one cycle.
- Streaming: 8 back-to-back reads of 0x00..0x07 (preloaded 0x100+i), ready=1 → 8 consecutive responses 0x100..0x107 in order, no ack gaps.
- Backpressure: ready=0, 5 reads with RESP_DEPTH=4 → 4 acked, 5th ack=0, rd_pending=4. Meanwhile a write is acked. Ready=1 → 5th acked one cycle after the first consume, all 5 returned in order.
- Reset mid-flight: 3 reads outstanding, assert rst_in → slave_resp=0 immediately. After release, no stale responses appear; memory data still readable.
- Address: read 0x40 with MEM_AW=6. With XBAR_SLAVE_ADDR_CHECK_EN → rdata=0, slave_err=1. Without → returns the word at 0x00, slave_err=0.
